// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared constants and helpers for the PWM output stage.
//   PWM_BITS        : width of the step counter and the duty-cycle byte
//   N_OUT           : number of user outputs
//   DUTY_FULL       : duty code meaning "high for the whole period"
//   CLK_DIV_DEFAULT : default prescaler divisor (10 MHz clk -> ~3 kHz PWM)
//   pre_width()     : prescaler register width for a given divisor
//   pwm_level_of()  : PWM compare for one step of the period
package pwm_pkg;

    localparam int PWM_BITS        = 8;
    localparam int N_OUT           = 16;
    localparam int CLK_DIV_DEFAULT = 13;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;

    // A divisor of 1 still needs a 1-bit register so the port widths stay legal.
    function automatic int pre_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Full-scale duty is forced high so 255 gives a solid level rather than
    // a 255/256 pulse with a one-step notch at the end of each period.
    function automatic logic pwm_level_of(input logic [PWM_BITS-1:0] cnt,
                                          input logic [PWM_BITS-1:0] duty_sh);
        logic level;
        if (duty_sh == DUTY_FULL) begin
            level = 1'b1;
        end else if (duty_sh == '0) begin
            level = 1'b0;
        end else begin
            level = (cnt < duty_sh);
        end
        return level;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase
// Free-running PWM time base: prescaler, 8-bit step counter and the duty
// shadow register that only changes at period boundaries.
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   duty         in   duty-cycle byte from the register file
//   cnt          out  current step within the period (0..255)
//   duty_sh      out  duty value in force for the current period
//   period_start out  high on the tick that wraps cnt from 255 to 0
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic [PWM_BITS-1:0] cnt,
    output logic [PWM_BITS-1:0] duty_sh,
    output logic                period_start
);

    localparam int                PRE_W    = pre_width(CLK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0] pre;
    logic             prime;
    logic             tick;

    assign tick         = (pre == PRE_LAST);
    assign period_start = tick && (cnt == CNT_LAST);

    // Prescaler: one tick every CLK_DIV cycles; with CLK_DIV=1 it sits at 0
    // and ticks every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Step counter advances once per tick and wraps naturally at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

    // prime makes the very first edge after reset capture duty, so the first
    // period already runs at the programmed duty instead of waiting a full
    // period with duty_sh=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime <= 1'b1;
        end else begin
            prime <= 1'b0;
        end
    end

    // Duty shadow only moves at a period boundary, so a mid-period write can
    // never shorten or stretch the pulse already in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
        end else if (prime || period_start) begin
            duty_sh <= duty;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral
// Output stage behind the SPI register file. Each of the 16 outputs is
// either off, a static high, or the common PWM waveform.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en_out  in   per-bit output enable ({addr1, addr0})
//   en_pwm  in   per-bit PWM select ({addr3, addr2}); only matters if enabled
//   duty    in   common duty cycle (addr4), applied at the next period start
//   out     out  registered user outputs
module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_OUT-1:0]    en_out,
    input  logic [N_OUT-1:0]    en_pwm,
    input  logic [PWM_BITS-1:0] duty,
    output logic [N_OUT-1:0]    out
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty_sh;
    logic                period_start_unused;
    logic                pwm_level;
    logic [N_OUT-1:0]    out_next;

    // The period marker is not needed here; it is kept on the time base for
    // anything that later wants to hook period boundaries.
    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty         (duty),
        .cnt          (cnt),
        .duty_sh      (duty_sh),
        .period_start (period_start_unused)
    );

    // All PWM bits share a single compare, so every PWM output is in phase.
    // A bit with en_pwm clear gets ~en_pwm=1 and is therefore a static high.
    always_comb begin
        pwm_level = pwm_level_of(cnt, duty_sh);
        out_next  = en_out & (~en_pwm | {N_OUT{pwm_level}});
    end

    // Registered outputs keep the pins free of compare glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_next;
        end
    end

endmodule
